// File: rtl/q5_drv_pkg.sv
// Shared definitions for the Q5 vector driver.
//   - widths of the step counter, settle counter and truth table
//   - FSM state enum (IDLE, SETTLE, FIN)
//   - Q5_EXPECTED: truth table of w = ~((c|d)&(~d|(a&b))), bit i = w for {a,b,c,d} = i
//   - vec_t: the {a,b,c,d} bundle driven into the gate (a is the MSB)
//   - order(): maps a sweep step to the input combination applied at that step
// Build option: define Q5_GRAY_ORDER_EN to sweep in Gray-code order
// (one input toggles per step); otherwise the sweep is a plain binary count.
package q5_drv_pkg;

  localparam int unsigned STEP_W  = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TRUTH_W = 16;

  localparam logic [TRUTH_W-1:0] Q5_EXPECTED = 16'h1BBB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    FIN    = 2'd2
  } state_t;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
  } vec_t;

  // Input combination applied at sweep step n.
  function automatic logic [STEP_W-1:0] order(input logic [STEP_W-1:0] n);
`ifdef Q5_GRAY_ORDER_EN
    return n ^ (n >> 1);
`else
    return n;
`endif
  endfunction

endpackage

// File: rtl/settle_counter.sv
// Settle-window down-counter for the Q5 vector driver.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset (count clears to 0)
//   load       : load load_val on the next edge (takes priority over en)
//   load_val   : reload value (window length minus one)
//   en         : decrement by one per edge while the count is non-zero
//   zero       : registered flag, high while the count is 0
module settle_counter
  import q5_drv_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // zero is computed from the value being written so it stays a register
  // yet always agrees with cnt_q.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      cnt_q <= load_val;
      zero  <= (load_val == '0);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
      zero  <= (cnt_q == CNT_W'(1));
    end
  end

endmodule

// File: rtl/q5_vector_driver.sv
// Q5 gate vector driver and truth-table collector.
// On start, steps {a,b,c,d} through all 16 combinations, holds each for
// SETTLE_CYC cycles, samples w at the last edge of each window into truth,
// then pulses done and flags mismatch when truth != EXPECTED.
// Build option: Q5_GRAY_ORDER_EN selects Gray-code sweep order (see q5_drv_pkg).
// Parameters:
//   SETTLE_CYC : cycles per vector, 1..255 (0 behaves as 1)
//   EXPECTED   : expected truth table, bit i = w for {a,b,c,d} = i
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   start      : sweep request (ignored while a sweep is in progress)
//   w          : gate output under test (X/Z captured as 0)
//   a,b,c,d    : registered gate inputs
//   busy       : sweep in progress
//   done       : one-cycle completion pulse
//   truth      : captured truth table
//   mismatch   : truth != EXPECTED, valid from done until the next start
module q5_vector_driver
  import q5_drv_pkg::*;
#(
  parameter int unsigned          SETTLE_CYC = 2,
  parameter logic [TRUTH_W-1:0]   EXPECTED   = Q5_EXPECTED
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               w,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               busy,
  output logic               done,
  output logic [TRUTH_W-1:0] truth,
  output logic               mismatch
);

  localparam int unsigned      SETTLE_EFF    = (SETTLE_CYC == 0) ? 1 : SETTLE_CYC;
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_EFF - 1);
  localparam logic [STEP_W-1:0] LAST_STEP    = STEP_W'(15);

  state_t              state_q,    state_d;
  logic [STEP_W-1:0]   step_q,     step_d;
  vec_t                vec_q,      vec_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic [TRUTH_W-1:0]  truth_q,    truth_d;
  logic                mismatch_q, mismatch_d;

  logic                cnt_load_c;
  logic                cnt_en_c;
  logic                cnt_zero;
  logic                w_bit_c;

  // Only a clean logic 1 counts as high; X or Z on w reads as 0.
  assign w_bit_c = (w === 1'b1);

  // Settle window timer.
  settle_counter u_settle (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cnt_load_c),
    .load_val (SETTLE_RELOAD),
    .en       (cnt_en_c),
    .zero     (cnt_zero)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    vec_d      = vec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    truth_d    = truth_q;
    mismatch_d = mismatch_q;
    cnt_load_c = 1'b0;
    cnt_en_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          truth_d    = '0;
          mismatch_d = 1'b0;
          step_d     = '0;
          vec_d      = vec_t'(order(STEP_W'(0)));
          busy_d     = 1'b1;
          cnt_load_c = 1'b1;
          state_d    = SETTLE;
        end
      end

      SETTLE: begin
        if (!cnt_zero) begin
          cnt_en_c = 1'b1;
        end else begin
          // Index by the combination actually applied, not by step number.
          truth_d[order(step_q)] = w_bit_c;
          if (step_q != LAST_STEP) begin
            step_d     = step_q + STEP_W'(1);
            vec_d      = vec_t'(order(step_q + STEP_W'(1)));
            cnt_load_c = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end

      FIN: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        mismatch_d = (truth_q != EXPECTED);
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      step_q     <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      truth_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      vec_q      <= vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      truth_q    <= truth_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign a        = vec_q.a;
  assign b        = vec_q.b;
  assign c        = vec_q.c;
  assign d        = vec_q.d;
  assign busy     = busy_q;
  assign done     = done_q;
  assign truth    = truth_q;
  assign mismatch = mismatch_q;

endmodule

// File: tb/tb_q5_vector_driver.sv
// Scoreboard bench for q5_vector_driver.
// The gate is modelled as a lookup into a 16-entry table (plus an X mask);
// each sweep pushes the expected {truth, mismatch, done cycle} and a
// negedge monitor pops and compares whenever done is seen.
module tb_q5_vector_driver;

  localparam int SET0 = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic        w, w1;
  logic        a, b, c, d, busy, done, mismatch;
  logic [15:0] truth;
  logic        a1, b1, c1, d1, busy1, done1, mismatch1;
  logic [15:0] truth1;

  logic [15:0] gate_tbl = 16'h0;
  logic [15:0] gate_x   = 16'h0;
  logic [15:0] ref_tbl  = 16'h0;
  logic [3:0]  idx, idx1;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] truth;
    logic        mism;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign idx  = {a, b, c, d};
  assign idx1 = {a1, b1, c1, d1};
  assign w    = gate_x[idx] ? 1'bx : gate_tbl[idx];
  assign w1   = ref_tbl[idx1];

  q5_vector_driver #(.SETTLE_CYC(SET0)) dut (
    .clk(clk), .rstn(rstn), .start(start), .w(w),
    .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .truth(truth), .mismatch(mismatch)
  );

  q5_vector_driver #(.SETTLE_CYC(0)) dut_short (
    .clk(clk), .rstn(rstn), .start(start1), .w(w1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .done(done1), .truth(truth1), .mismatch(mismatch1)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference gate: w = ~((c|d)&(~d|(a&b))), tabulated over {a,b,c,d}.
  function automatic logic [15:0] q5_table();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) begin
      logic ai, bi, ci, di;
      ai = i[3]; bi = i[2]; ci = i[1]; di = i[0];
      t[i] = ~((ci | di) & (~di | (ai & bi)));
    end
    return t;
  endfunction

  // Faulty gate: w = ~(a&b).
  function automatic logic [15:0] nand_ab_table();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = ~(i[3] & i[2]);
    return t;
  endfunction

  function automatic logic [3:0] tb_order(input int n);
`ifdef Q5_GRAY_ORDER_EN
    return 4'(n ^ (n >> 1));
`else
    return 4'(n);
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("truth", 32'(truth), 32'(mon_e.truth));
        check("mismatch", 32'(mismatch), 32'(mon_e.mism));
        check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [15:0] tbl, input logic [15:0] xm, input int dcyc);
    exp_t e;
    e.truth    = tbl & ~xm;
    e.mism     = ((tbl & ~xm) != 16'h1BBB);
    e.done_cyc = dcyc;
    sb.push_back(e);
  endtask

  // One sweep; called on a negedge. inject pulses start at steps 5 and 20.
  task automatic sweep(input logic [15:0] tbl, input logic [15:0] xm, input bit inject);
    int c0, errs, busy_errs;
    logic [3:0] prev, cur;
    logic exp_m;
    gate_tbl = tbl;
    gate_x   = xm;
    start    = 1'b1;
    c0       = cyc + 1;
    exp_m    = ((tbl & ~xm) != 16'h1BBB);
    push_exp(tbl, xm, c0 + 16 * SET0 + 1);
    @(negedge clk);
    start = 1'b0;
    errs  = 0;
    prev  = {a, b, c, d};
    for (int k = 0; k < 16 * SET0; k++) begin
      cur = {a, b, c, d};
      if (cur !== tb_order(k / SET0)) errs++;
      if (busy !== 1'b1) errs++;
`ifdef Q5_GRAY_ORDER_EN
      if (k > 0 && cur !== prev && $countones(cur ^ prev) != 1) errs++;
`endif
      prev  = cur;
      start = (inject && (k == 5 || k == 20));
      @(negedge clk);
    end
    start = 1'b0;
    check("vector_seq", 32'(errs), 32'd0);
    repeat (2) @(negedge clk);
    check("mismatch_hold", 32'(mismatch), 32'(exp_m));
    check("truth_hold", 32'(truth), 32'(tbl & ~xm));
    if (inject) begin
      busy_errs = 0;
      repeat (40) begin
        if (busy !== 1'b0) busy_errs++;
        @(negedge clk);
      end
      check("no_second_sweep", 32'(busy_errs), 32'd0);
    end
  endtask

  // start held high through FIN: a second sweep begins the cycle after FIN.
  task automatic held_start(input logic [15:0] tbl);
    int c0, n;
    gate_tbl = tbl;
    gate_x   = 16'h0;
    start    = 1'b1;
    c0       = cyc + 1;
    push_exp(tbl, 16'h0, c0 + 16 * SET0 + 1);
    push_exp(tbl, 16'h0, c0 + 16 * SET0 + 2 + 16 * SET0 + 1);
    repeat (16 * SET0 + 3) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("held_start_drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_abcd"}, 32'({a, b, c, d}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_truth"}, 32'(truth), 32'd0);
    check({tag, "_mismatch"}, 32'(mismatch), 32'd0);
  endtask

  // Reset mid-sweep: outputs clear without a clock edge, no done follows.
  task automatic reset_mid(input logic [15:0] tbl);
    gate_tbl = tbl;
    gate_x   = 16'h0;
    start    = 1'b1;
    push_exp(tbl, 16'h0, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    reset_values("mid_reset");
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_idle", 32'(busy), 32'd0);
  endtask

  // SETTLE_CYC=0 behaves as 1: done 17 cycles after start.
  task automatic short_settle();
    int n;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (done1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("short_latency", 32'(n), 32'd17);
    @(negedge clk);
  endtask

  initial begin
    ref_tbl  = q5_table();
    gate_tbl = ref_tbl;
    #2;
    reset_values("por");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    sweep(ref_tbl, 16'h0, 1'b0);
    sweep(nand_ab_table(), 16'h0, 1'b0);
    sweep(ref_tbl, 16'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] t, xm;
      t  = 16'($urandom);
      xm = (i % 2 == 1) ? 16'($urandom & $urandom & $urandom) : 16'h0;
      sweep(t, xm, 1'b0);
    end
    held_start(ref_tbl);
    reset_mid(nand_ab_table());
    short_settle();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/q5_vector_driver.md
# q5_vector_driver

Upstream driver and result collector for the Q5 transistor-level gate. On a start request it steps the gate's four inputs `a,b,c,d` through all 16 combinations and holds each one for a programmable settle window that covers the gate's rise/fall/turn-off delays. It then samples the gate output `w` into a 16-bit truth table and, when the sweep finishes, compares that table with the expected function. It sits between the bench/control logic and the `Q5_gate` instance in characterisation benches.

## Interface
- `SETTLE_CYC`, default 2: number of clock cycles each vector is held before `w` is sampled; legal range 1..255, and 0 is treated as 1.
- `EXPECTED`, default 16'h1BBB: expected truth table, where bit i is the value of `w` for input `{a,b,c,d}` = i (a is the MSB). This default corresponds to w = ~((c|d)&(~d|(a&b))).
- `clk  in  1`: clock. Reset is asynchronous and active-low; there is one clock.
- `rstn  in  1`: asynchronous, active-low reset.
- `start  in  1`: sweep request, sampled at posedge.
- `w  in  1`: gate output under test.
- `a, b, c, d  out  1 each`: gate inputs, registered.
- `busy  out  1`: high while a sweep is in progress.
- `done  out  1`: one-cycle pulse when the sweep completes.
- `truth  out  16`: captured truth table.
- `mismatch  out  1`: `truth != EXPECTED`; valid from `done` onward.

## Operation
- State machine with three states: IDLE, SETTLE, FIN.
- **Reset** (`rstn`=0, takes effect immediately):
  - state = IDLE.
  - `a,b,c,d` = 0, `busy` = 0, `done` = 0, `truth` = 0, `mismatch` = 0.
  - step counter = 0, settle counter = 0.
- **IDLE**
  - `start`=1 → clear `truth` and `mismatch`, set step = 0, drive vector `order(0)`, load the settle counter with `SETTLE_CYC-1`, set `busy`=1, go to SETTLE.
  - `start`=0 → stay in IDLE; all outputs hold.
- **SETTLE**
  - If the settle counter ≠ 0, decrement it.
  - If it = 0:
    - Capture: `truth[order(step)]` ← (`w` === 1'b1). An X or Z on `w` is captured as 0.
    - If step < 15: increment step, drive `order(step+1)`, reload the counter, stay in SETTLE.
    - If step = 15: go to FIN.
- **FIN**: `done`=1 for this one cycle, `busy`=0, `mismatch` ← (`truth` != `EXPECTED`), go to IDLE. `a,b,c,d` keep the last vector driven.
- **Vector order**: `order(n)` = n (plain binary count) by default. The step counter is 4 bits and never wraps, because step 15 always exits to FIN.
- **Start while busy**: `start` asserted in SETTLE or FIN is ignored and is not queued.
- **Start held high**: `start` held high across FIN begins a new sweep on the cycle after FIN, since that is when the machine is back in IDLE.
- **Reset mid-sweep**: aborts the sweep immediately. No `done` pulse is produced and the partial `truth` is cleared.

## Timing
- `start` is sampled at edge T0. `a,b,c,d` show vector 0 after T0.
- Each vector is driven for exactly `SETTLE_CYC` cycles. The sample point is the last edge of that window.
- `done` goes high `16*SETTLE_CYC + 1` cycles after T0. For `SETTLE_CYC`=2 that is 33 cycles.
- `busy` is high from T0 until the FIN cycle.
- `truth` is final from the edge that enters FIN.
- `mismatch` is valid together with `done` and holds until the next `start` is accepted or a reset occurs.
- The settle window in time (`SETTLE_CYC` × clock period) must exceed the gate's worst-case delay. At the 1 ns timescale with a 10 ns clock, `SETTLE_CYC`=2 gives 20 ns against a worst path of about 18 ns (two series devices at 9 ns each).

## Configuration
- `Q5_GRAY_ORDER_EN` defined:
  - `order(n)` = n ^ (n >> 1), so exactly one input toggles per step. This avoids multi-input switching hazards on `w`.
  - Capture is still indexed by the actual combination, so for a correct gate `truth` and `mismatch` are identical to the non-Gray build.
- `Q5_GRAY_ORDER_EN` not defined: `order(n)` = n, binary order.

## Structure
- Package `q5_drv_pkg` contains:
  - the state enum (IDLE, SETTLE, FIN);
  - the localparam `Q5_EXPECTED` = 16'h1BBB;
  - the function `order(logic [3:0] n)`, which contains the `ifdef Q5_GRAY_ORDER_EN` selection.
- One sub-module: `settle_counter`, an 8-bit down-counter with `load`/`zero` outputs and async active-low reset, instantiated once.
- The FSM, step counter and truth register live in `q5_vector_driver`.

## Test plan
- **Reset values**: assert `rstn`=0 mid-run → `a,b,c,d`, `busy`, `done`, `truth`, `mismatch` all read 0 immediately, with no clock edge needed.
- **Nominal sweep against the real `Q5_gate`**: `SETTLE_CYC`=2, pulse `start` → `done` exactly 33 cycles later, `truth`=16'h1BBB, `mismatch`=0.
- **Faulty gate model**: model `w` as ~(a&b) → `truth`=16'h0FFF, `mismatch`=1 at `done`.
- **Start during sweep**: `start` pulses at cycles 5 and 20 → exactly one `done` pulse at cycle 33 and no second sweep.
- **Gray build** (`Q5_GRAY_ORDER_EN`): monitor confirms exactly one of `a,b,c,d` changes per step (sequence 0,1,3,2,6,...,8) → `truth`=16'h1BBB.
- **Short settle window**: `SETTLE_CYC`=0 → behaves as 1, `done` 17 cycles after `start`. With a 10 ns clock the late samples capture stale `w`, so a mismatch is allowed and only the cycle count is checked.
